// File: rtl/cdb_pkg.sv
// Shared CDB definitions: field widths and the {val, id} entry that travels
// from functional units through the result FIFOs onto the common data bus.
package cdb_pkg;

  localparam int CDB_VAL_W = 8;
  localparam int CDB_ID_W  = 4;

  typedef struct packed {
    logic [CDB_VAL_W-1:0] val;
    logic [CDB_ID_W-1:0]  id;
  } cdb_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Small circular result FIFO, one per functional unit. Flush empties it and
// wins over a simultaneous push/pop; push when full and pop when empty are ignored.
module result_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = cdb_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next pointer/count; a simultaneous push and pop leaves the count alone.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, a round-robin grant across the
// FIFO heads and a registered broadcast of one result per cycle.
// Build option: define CDB_BYPASS_EN to let an FU with an empty FIFO compete
// directly with its live input, cutting accept-to-broadcast latency to one edge.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int  FU_COUNT  = 8,
  parameter int  BUF_DEPTH = 2,
  localparam int FUID_W    = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FU_COUNT-1:0]           fu_valid,
  input  logic [FU_COUNT*CDB_VAL_W-1:0] fu_val,
  input  logic [FU_COUNT*CDB_ID_W-1:0]  fu_robid,
  output logic [FU_COUNT-1:0]           fu_ready,
  output logic [CDB_VAL_W-1:0]          cdbval,
  output logic [CDB_ID_W-1:0]           cdbid,
  output logic                          cdbtransmit,
  output logic [FUID_W-1:0]             cdb_fuid
);

  cdb_entry_t           fu_in [FU_COUNT];
  cdb_entry_t           head  [FU_COUNT];
  logic [CNT_W-1:0]     count [FU_COUNT];
  logic [FU_COUNT-1:0]  full, empty, push, pop, req, byp_take;

  logic                 gnt_vld;
  logic [FUID_W-1:0]    gnt_idx;
  cdb_entry_t           gnt_data;

  logic [FUID_W-1:0]    rr_q, rr_d;
  logic [CDB_VAL_W-1:0] val_q, val_d;
  logic [CDB_ID_W-1:0]  id_q, id_d;
  logic [FUID_W-1:0]    fuid_q, fuid_d;
  logic                 tx_q, tx_d;

  for (genvar gi = 0; gi < FU_COUNT; gi++) begin : g_fu
    assign fu_in[gi]    = {fu_val[gi*CDB_VAL_W +: CDB_VAL_W], fu_robid[gi*CDB_ID_W +: CDB_ID_W]};
    // Ready comes from registered occupancy only, never from this cycle's grant.
    assign fu_ready[gi] = (count[gi] < CNT_W'(BUF_DEPTH));
    assign push[gi]     = fu_valid[gi] && !full[gi] && !byp_take[gi];
    assign pop[gi]      = gnt_vld && (gnt_idx == FUID_W'(gi)) && !empty[gi];

    result_fifo #(
      .DEPTH   (BUF_DEPTH),
      .entry_t (cdb_entry_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (fu_in[gi]),
      .head  (head[gi]),
      .count (count[gi]),
      .full  (full[gi]),
      .empty (empty[gi])
    );
  end

`ifdef CDB_BYPASS_EN
  // An empty FIFO with a live input may compete; if it wins, the input skips the FIFO.
  assign req      = ~empty | (empty & fu_valid);
  for (genvar gb = 0; gb < FU_COUNT; gb++) begin : g_byp
    assign byp_take[gb] = gnt_vld && (gnt_idx == FUID_W'(gb)) && empty[gb];
  end
  assign gnt_data = empty[gnt_idx] ? fu_in[gnt_idx] : head[gnt_idx];
`else
  assign req      = ~empty;
  assign byp_take = '0;
  assign gnt_data = head[gnt_idx];
`endif

  // Round-robin scan starting at rr_q; the first requester found wins.
  always_comb begin : rr_scan
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < FU_COUNT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= FU_COUNT) idx = idx - FU_COUNT;
      if (!gnt_vld && req[FUID_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = FUID_W'(idx);
      end
    end
  end

  // Next pointer and broadcast contents; flush clears everything, no grant drives zeros.
  always_comb begin
    rr_d   = rr_q;
    tx_d   = 1'b0;
    val_d  = '0;
    id_d   = '0;
    fuid_d = '0;
    if (flush) begin
      rr_d = '0;
    end else if (gnt_vld) begin
      rr_d   = (gnt_idx == FUID_W'(FU_COUNT - 1)) ? '0 : gnt_idx + FUID_W'(1);
      tx_d   = 1'b1;
      val_d  = gnt_data.val;
      id_d   = gnt_data.id;
      fuid_d = gnt_idx;
    end
  end

  // Round-robin pointer and the CDB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= '0;
      tx_q   <= 1'b0;
      val_q  <= '0;
      id_q   <= '0;
      fuid_q <= '0;
    end else begin
      rr_q   <= rr_d;
      tx_q   <= tx_d;
      val_q  <= val_d;
      id_q   <= id_d;
      fuid_q <= fuid_d;
    end
  end

  assign cdbtransmit = tx_q;
  assign cdbval      = val_q;
  assign cdbid       = id_q;
  assign cdb_fuid    = fuid_q;

endmodule
